// File: rtl/servo_slew_ctrl_pkg.sv
// Shared definitions for the servo slew controller: angle range, FSM states
// and the small input-conditioning helpers applied when a target is accepted.
package servo_pkg;

   localparam int                 ANGLE_W   = 9;
   localparam logic [ANGLE_W-1:0] MAX_ANGLE = 9'd180;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Requested angles beyond the mechanical range are pinned to the end stop.
   function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
      if (a > MAX_ANGLE) begin
         return MAX_ANGLE;
      end else begin
         return a;
      end
   endfunction

   // A zero step would never converge, so it is promoted to one degree.
   function automatic logic [3:0] eff_step(input logic [3:0] s);
      if (s == 4'd0) begin
         return 4'd1;
      end else begin
         return s;
      end
   endfunction

endpackage

// File: rtl/servo_slew_ctrl_if.sv
// Target handshake and status bundle between the requester and the slew
// controller. The requester side is the master.
interface servo_slew_ctrl_if;
   import servo_pkg::*;

   logic [ANGLE_W-1:0] tgt_angle;
   logic [3:0]         tgt_step;
   logic               tgt_valid;
   logic               tgt_ready;
   logic [ANGLE_W-1:0] angle;
   logic               busy;
   logic               done;
   logic               frame_tick;

   modport master (
      output tgt_angle, tgt_step, tgt_valid,
      input  tgt_ready, angle, busy, done, frame_tick
   );

   modport slave (
      input  tgt_angle, tgt_step, tgt_valid,
      output tgt_ready, angle, busy, done, frame_tick
   );

endinterface

// File: rtl/servo_slew_ctrl_frame_tick.sv
// Free-running servo frame counter; tick marks the last cycle of each frame.
module servo_frame_tick #(
   parameter int FRAME_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   // Count 0..FRAME_CYCLES-1 and wrap, independent of controller state.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_count <= '0;
      end else if (r_count == CNT_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign tick = (r_count == CNT_LAST);

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo slew-rate controller: accepts a target angle and moves the commanded
// angle toward it by a bounded step once per frame, then waits a number of
// settle frames before signalling done.
module servo_slew_ctrl
   import servo_pkg::*;
#(
   parameter int FRAME_CYCLES = 2_000_000,
   parameter int HOLD_FRAMES  = 5,
   parameter int RESET_ANGLE  = 90
) (
   input  logic              clk,
   input  logic              clr,
   servo_slew_ctrl_if.slave  bus
);

   localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
   localparam logic [ANGLE_W-1:0] ANGLE_RST = ANGLE_W'(RESET_ANGLE);

   state_t             r_state, w_state_nxt;
   logic [ANGLE_W-1:0] r_angle, w_angle_nxt;
   logic [ANGLE_W-1:0] r_target, w_target_nxt;
   logic [3:0]         r_step, w_step_nxt;
   logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
   logic               r_done_idle, w_done_idle_nxt;
   logic               w_done_now;

   logic               w_tick;
   logic               w_accept;
   logic [ANGLE_W-1:0] w_tgt_clamped;
   logic [3:0]         w_tgt_step_eff;
   logic signed [9:0]  w_diff;
   logic [9:0]         w_dist;
   logic [ANGLE_W-1:0] w_slew_angle;

   servo_frame_tick #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame (
      .clk  (clk),
      .clr  (clr),
      .tick (w_tick)
   );

   assign w_accept       = bus.tgt_valid & bus.tgt_ready;
   assign w_tgt_clamped  = clamp_angle(bus.tgt_angle);
   assign w_tgt_step_eff = eff_step(bus.tgt_step);

   // Signed distance to the target in 10 bits so no operand combination wraps;
   // the final add/sub cannot leave 0..180 because it never passes the target.
   assign w_diff       = $signed({1'b0, r_target}) - $signed({1'b0, r_angle});
   assign w_dist       = w_diff[9] ? $unsigned(-w_diff) : $unsigned(w_diff);
   assign w_slew_angle = (w_dist <= {6'd0, r_step}) ? r_target :
                         (w_diff[9] ? (r_angle - {5'd0, r_step})
                                    : (r_angle + {5'd0, r_step}));

   // Next-state and datapath decisions; a coinciding accept only changes the
   // target for later ticks and suppresses settling on the old target.
   always_comb begin
      w_state_nxt     = r_state;
      w_angle_nxt     = r_angle;
      w_target_nxt    = r_target;
      w_step_nxt      = r_step;
      w_hold_nxt      = r_hold_cnt;
      w_done_idle_nxt = 1'b0;
      w_done_now      = 1'b0;

      if (w_accept) begin
         w_target_nxt = w_tgt_clamped;
         w_step_nxt   = w_tgt_step_eff;
      end else begin
         w_target_nxt = r_target;
      end

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_tgt_clamped == r_angle) begin
                  w_done_idle_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_MOVE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MOVE: begin
            if (w_tick) begin
               w_angle_nxt = w_slew_angle;
               if ((w_slew_angle == r_target) && !w_accept) begin
                  if (HOLD_FRAMES == 0) begin
                     w_state_nxt = ST_IDLE;
                     w_done_now  = 1'b1;
                  end else begin
                     w_state_nxt = ST_HOLD;
                     w_hold_nxt  = '0;
                  end
               end else begin
                  w_state_nxt = ST_MOVE;
               end
            end else begin
               w_state_nxt = ST_MOVE;
            end
         end
         ST_HOLD: begin
            if (w_tick) begin
               if (r_hold_cnt == HOLD_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_done_now  = 1'b1;
               end else begin
                  w_hold_nxt = r_hold_cnt + HOLD_W'(1);
               end
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Controller state and datapath registers; reset abandons any move silently.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state     <= ST_IDLE;
         r_angle     <= ANGLE_RST;
         r_target    <= ANGLE_RST;
         r_step      <= 4'd1;
         r_hold_cnt  <= '0;
         r_done_idle <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_angle     <= w_angle_nxt;
         r_target    <= w_target_nxt;
         r_step      <= w_step_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_done_idle <= w_done_idle_nxt;
      end
   end

   assign bus.angle      = r_angle;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.tgt_ready  = (r_state != ST_HOLD);
   assign bus.done       = r_done_idle | w_done_now;
   assign bus.frame_tick = w_tick;

endmodule
